// File: rtl/uart_alu_pkg.sv
// Shared definitions for the uart_alu packet engine: opcodes, FSM states, header size.
// Opcode 0x14 (DIV) is only treated as arithmetic when UART_ALU_DIV_EN is defined.
package uart_alu_pkg;

    localparam int unsigned HDR_LEN = 4;

    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_SUB  = 8'h11;
    localparam logic [7:0] OP_XOR  = 8'h12;
    localparam logic [7:0] OP_MUL  = 8'h13;
    localparam logic [7:0] OP_DIV  = 8'h14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_OPERAND,
        ST_EXEC,
        ST_RUN,
        ST_RESULT,
        ST_ECHO,
        ST_DRAIN
    } state_e;

    // Opcodes served by the iterative unit
    function automatic logic is_muldiv(input logic [7:0] op);
`ifdef UART_ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

    function automatic logic is_arith(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || is_muldiv(op);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier (low word) and, with UART_ALU_DIV_EN, a restoring divider.
// One bit per cycle, width_p cycles per operation; done_o pulses once with result_o valid.
module alu_seq_muldiv #(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
`ifdef UART_ALU_DIV_EN
    input  logic               div_i,
`endif
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               done_o,
    output logic [width_p-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(width_p + 1);

    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [width_p-1:0] a_q;
    logic [width_p-1:0] b_q;
    logic [width_p-1:0] r_q;

`ifdef UART_ALU_DIV_EN
    logic               div_q;
    logic [width_p:0]   rem_sh_c;
    logic [width_p-1:0] rem_diff_c;
    logic               rem_ge_c;

    // a_q doubles as dividend shifter and quotient collector; divisor 0 yields all-ones
    always_comb begin
        rem_sh_c   = {r_q, a_q[width_p-1]};
        rem_ge_c   = rem_sh_c >= {1'b0, b_q};
        rem_diff_c = width_p'(rem_sh_c - {1'b0, b_q});
    end

    assign result_o = div_q ? a_q : r_q;
`else
    assign result_o = r_q;
`endif

    assign done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
`ifdef UART_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(width_p);
                a_q    <= a_i;
                b_q    <= b_i;
                r_q    <= '0;
`ifdef UART_ALU_DIV_EN
                div_q  <= div_i;
`endif
            end else if (busy_q) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
`ifdef UART_ALU_DIV_EN
                if (div_q) begin
                    if (rem_ge_c) begin
                        r_q <= rem_diff_c;
                        a_q <= {a_q[width_p-2:0], 1'b1};
                    end else begin
                        r_q <= rem_sh_c[width_p-1:0];
                        a_q <= {a_q[width_p-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    if (b_q[0]) r_q <= r_q + a_q;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_alu_engine.sv
// Packet ALU between UART rx and tx byte streams: parses header, folds operands, streams result LSB first.
// Define UART_ALU_DIV_EN to enable opcode 0x14 (unsigned division); otherwise it is rejected.
module uart_alu_engine
    import uart_alu_pkg::*;
#(
    parameter int unsigned datawidth_p     = 8,
    parameter int unsigned operand_width_p = 32,
    parameter int unsigned max_len_p       = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [datawidth_p-1:0] rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [datawidth_p-1:0] tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned DW     = datawidth_p;
    localparam int unsigned W      = operand_width_p;
    localparam int unsigned B      = W / DW;
    localparam int unsigned BCNT_W = 4;

    state_e              state_q, state_d;
    logic [7:0]          opcode_q;
    logic [DW-1:0]       len_lo_q;
    logic [15:0]         rem_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic                first_q;
    logic [W-1:0]        acc_q;
    logic [W-1:0]        opnd_q;
    logic                start_q;
    logic                tx_valid_q;
    logic [DW-1:0]       tx_data_q;
    logic                err_q;

    logic                rx_fire_c;
    logic [15:0]         len_c;
    logic [15:0]         plen_c;
    logic                len_bad_c;
    logic                shape_bad_c;
    logic                byte_last_c;
    logic                pay_last_c;
    logic                err_c;
    logic [W-1:0]        opnd_nxt_c;
    logic [W-1:0]        alu_c;
    logic                md_done;
    logic [W-1:0]        md_result;

    // Handshake-facing outputs; ECHO is a combinational pass-through
    always_comb begin
        busy_o     = (state_q != ST_IDLE);
        err_o      = err_q;
        tx_valid_o = tx_valid_q;
        tx_data_o  = tx_data_q;
        rx_ready_o = 1'b0;
        case (state_q)
            ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_OPERAND, ST_DRAIN: rx_ready_o = 1'b1;
            ST_ECHO: begin
                rx_ready_o = tx_ready_i;
                tx_valid_o = rx_valid_i;
                tx_data_o  = rx_data_i;
            end
            default: rx_ready_o = 1'b0;
        endcase
    end

    always_comb begin
        rx_fire_c   = rx_valid_i && rx_ready_o;
        len_c       = {rx_data_i, len_lo_q};
        plen_c      = len_c - 16'(HDR_LEN);
        len_bad_c   = (len_c < 16'(HDR_LEN)) || (32'(len_c) > max_len_p);
        shape_bad_c = (plen_c == 16'd0) || ((plen_c % 16'(B)) != 16'd0);
        byte_last_c = (bcnt_q == BCNT_W'(B - 1));
        pay_last_c  = (rem_q == 16'd1);
        opnd_nxt_c  = (opnd_q >> DW) | (W'(rx_data_i) << (W - DW));
        case (opcode_q)
            OP_ADD:  alu_c = acc_q + opnd_q;
            OP_SUB:  alu_c = acc_q - opnd_q;
            OP_XOR:  alu_c = acc_q ^ opnd_q;
            default: alu_c = acc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and header validation
    always_comb begin
        state_d = state_q;
        err_c   = 1'b0;
        case (state_q)
            ST_IDLE:   if (rx_fire_c) state_d = ST_RSVD;
            ST_RSVD:   if (rx_fire_c) state_d = ST_LEN_LO;
            ST_LEN_LO: if (rx_fire_c) state_d = ST_LEN_HI;
            ST_LEN_HI: if (rx_fire_c) begin
                if (len_bad_c) begin
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (opcode_q == OP_ECHO) begin
                    state_d = (plen_c == 16'd0) ? ST_IDLE : ST_ECHO;
                end else if (!is_arith(opcode_q) || shape_bad_c) begin
                    err_c   = 1'b1;
                    state_d = (plen_c == 16'd0) ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_OPERAND;
                end
            end
            ST_OPERAND: if (rx_fire_c && byte_last_c) begin
                if (first_q)                  state_d = pay_last_c ? ST_RESULT : ST_OPERAND;
                else if (is_muldiv(opcode_q)) state_d = ST_RUN;
                else                          state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = (rem_q == 16'd0) ? ST_RESULT : ST_OPERAND;
            ST_RUN:    if (md_done) state_d = (rem_q == 16'd0) ? ST_RESULT : ST_OPERAND;
            ST_RESULT: if (tx_valid_q && tx_ready_i && byte_last_c) state_d = ST_IDLE;
            ST_ECHO, ST_DRAIN: if (rx_fire_c && pay_last_c) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: header capture, operand shifting, accumulator and result serialiser
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            bcnt_q     <= '0;
            first_q    <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            start_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q   <= err_c;
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE:   if (rx_fire_c) opcode_q <= rx_data_i;
                ST_LEN_LO: if (rx_fire_c) len_lo_q <= rx_data_i;
                ST_LEN_HI: if (rx_fire_c) begin
                    rem_q   <= plen_c;
                    bcnt_q  <= '0;
                    first_q <= 1'b1;
                end
                ST_OPERAND: if (rx_fire_c) begin
                    rem_q <= rem_q - 16'd1;
                    if (byte_last_c) begin
                        bcnt_q  <= '0;
                        first_q <= 1'b0;
                        if (first_q) begin
                            acc_q <= opnd_nxt_c;
                        end else begin
                            opnd_q  <= opnd_nxt_c;
                            start_q <= is_muldiv(opcode_q);
                        end
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                        opnd_q <= opnd_nxt_c;
                    end
                end
                ST_EXEC: acc_q <= alu_c;
                ST_RUN:  if (md_done) acc_q <= md_result;
                // acc is consumed as a shift register while the result drains
                ST_RESULT: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= acc_q[DW-1:0];
                        acc_q      <= acc_q >> DW;
                    end else if (tx_ready_i) begin
                        if (byte_last_c) begin
                            tx_valid_q <= 1'b0;
                        end else begin
                            tx_data_q <= acc_q[DW-1:0];
                            acc_q     <= acc_q >> DW;
                            bcnt_q    <= bcnt_q + BCNT_W'(1);
                        end
                    end
                end
                ST_ECHO, ST_DRAIN: if (rx_fire_c) rem_q <= rem_q - 16'd1;
                default: ;
            endcase
        end
    end

    alu_seq_muldiv #(
        .width_p (W)
    ) u_muldiv (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_q),
`ifdef UART_ALU_DIV_EN
        .div_i    (opcode_q == OP_DIV),
`endif
        .a_i      (acc_q),
        .b_i      (opnd_q),
        .done_o   (md_done),
        .result_o (md_result)
    );

endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed self-checking bench for uart_alu_engine (operand_width_p = 32).
// DIV vectors depend on whether UART_ALU_DIV_EN is defined for the build.
module tb_uart_alu_engine;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready = 1'b1;
    logic       busy_o;
    logic       err_o;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int tx_mode = 0;
    byte_q_t tx_q;

    uart_alu_engine dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    // tx sink readiness: 0 = always ready, 1 = toggling, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (tx_mode)
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    // Record every accepted tx byte and every err pulse
    always @(posedge clk) begin
        if (rst_ni) begin
            if (tx_valid_o && tx_ready) tx_q.push_back(tx_data_o);
            if (err_o) err_cnt++;
            if (err_o && tx_valid_o) overlap_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] tx_word();
        logic [31:0] w = 'x;
        if (tx_q.size() >= 4) w = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
        return w;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready_o && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%02h waited=%0d limit=300", b, t);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t pkt);
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (tx_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic clear_obs();
        tx_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready_o); end
        checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid_o); end
        checks++; if (tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%02h exp=00", tx_data_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        byte_q_t p;
        clear_obs();
        p = '{8'h10, 8'h04, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt(p);
        checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL add_lat_c0 tx_valid got=%b exp=0", tx_valid_o); end
        @(negedge clk);
        checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL add_lat_c1 tx_valid got=%b exp=0", tx_valid_o); end
        @(negedge clk);
        checks++; if (tx_valid_o !== 1'b1) begin failures++; $display("FAIL add_lat_c2 tx_valid got=%b exp=1", tx_valid_o); end
        wait_tx(4);
        repeat (3) @(negedge clk);
        checks++; if (tx_q.size() != 4) begin failures++; $display("FAIL add_count got=%0d exp=4", tx_q.size()); end
        checks++; if (tx_word() !== 32'h0000_0000) begin failures++; $display("FAIL add_wrap got=%08h exp=00000000", tx_word()); end
        checks++; if (err_cnt != 0) begin failures++; $display("FAIL add_err got=%0d exp=0", err_cnt); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL add_idle busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_mul();
        byte_q_t p;
        int run = 0;
        clear_obs();
        p = '{8'h13, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        while (busy_o && !rx_ready_o && !tx_valid_o && run < 200) begin
            run++;
            @(negedge clk);
        end
        checks++; if (run < 32 || run >= 200) begin failures++; $display("FAIL mul_run_cycles got=%0d exp=32..199", run); end
        wait_tx(4);
        repeat (2) @(negedge clk);
        checks++; if (tx_q.size() != 4) begin failures++; $display("FAIL mul_count got=%0d exp=4", tx_q.size()); end
        checks++; if (tx_word() !== 32'h0000_000F) begin failures++; $display("FAIL mul_result got=%08h exp=0000000f", tx_word()); end
    endtask

    task automatic test_single_and_xor();
        byte_q_t p;
        clear_obs();
        p = '{8'h10, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_pkt(p);
        wait_tx(4);
        repeat (2) @(negedge clk);
        checks++; if (tx_word() !== 32'h1234_5678) begin failures++; $display("FAIL single_operand got=%08h exp=12345678", tx_word()); end
        clear_obs();
        p = '{8'h12, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00,
              8'h0F, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_tx(4);
        repeat (2) @(negedge clk);
        checks++; if (tx_q.size() != 4) begin failures++; $display("FAIL xor_count got=%0d exp=4", tx_q.size()); end
        checks++; if (tx_word() !== 32'h0000_00F1) begin failures++; $display("FAIL xor3_result got=%08h exp=000000f1", tx_word()); end
    endtask

    task automatic test_echo();
        byte_q_t p;
        logic [23:0] w;
        clear_obs();
        tx_mode = 1;
        p = '{8'h01, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(p);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL echo_idle busy got=%b exp=0", busy_o); end
        tx_mode = 0;
        repeat (4) @(negedge clk);
        w = 'x;
        if (tx_q.size() >= 3) w = {tx_q[2], tx_q[1], tx_q[0]};
        checks++; if (tx_q.size() != 3) begin failures++; $display("FAIL echo_count got=%0d exp=3", tx_q.size()); end
        checks++; if (w !== 24'hCCBBAA) begin failures++; $display("FAIL echo_bytes got=%06h exp=ccbbaa", w); end
        checks++; if (err_cnt != 0) begin failures++; $display("FAIL echo_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_malformed();
        byte_q_t p;
        clear_obs();
        p = '{8'h10, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
        send_pkt(p);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL drain_idle busy got=%b exp=0", busy_o); end
        @(negedge clk);
        checks++; if (err_cnt != 1) begin failures++; $display("FAIL drain_err_pulses got=%0d exp=1", err_cnt); end
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL drain_no_tx got=%0d exp=0", tx_q.size()); end
        p = '{8'h10, 8'h00, 8'h02, 8'h00};
        send_pkt(p);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL short_len_idle busy got=%b exp=0", busy_o); end
        @(negedge clk);
        checks++; if (err_cnt != 2) begin failures++; $display("FAIL short_len_err got=%0d exp=2", err_cnt); end
        p = '{8'h10, 8'h00, 8'h01, 8'h04};
        send_pkt(p);
        @(negedge clk);
        checks++; if (err_cnt != 3) begin failures++; $display("FAIL long_len_err got=%0d exp=3", err_cnt); end
        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_tx(4);
        repeat (2) @(negedge clk);
        checks++; if (tx_word() !== 32'h0000_0005) begin failures++; $display("FAIL add_after_err got=%08h exp=00000005", tx_word()); end
        clear_obs();
        p = '{8'h01, 8'h00, 8'h04, 8'h00};
        send_pkt(p);
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || err_cnt != 0 || tx_q.size() != 0) begin
            failures++;
            $display("FAIL echo_empty busy=%b err=%0d tx=%0d exp=0/0/0", busy_o, err_cnt, tx_q.size());
        end
    endtask

    task automatic test_backpressure();
        byte_q_t p;
        int t = 0;
        int stable = 0;
        clear_obs();
        tx_mode = 2;
        p = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        while (!tx_valid_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 20; i++) begin
            if (tx_valid_o === 1'b1 && tx_data_o === 8'hFE) stable++;
            @(negedge clk);
        end
        checks++; if (stable != 20) begin failures++; $display("FAIL sub_hold_stable got=%0d exp=20", stable); end
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL sub_hold_no_accept got=%0d exp=0", tx_q.size()); end
        tx_mode = 0;
        wait_tx(4);
        repeat (3) @(negedge clk);
        checks++; if (tx_q.size() != 4) begin failures++; $display("FAIL sub_count got=%0d exp=4", tx_q.size()); end
        checks++; if (tx_word() !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_result got=%08h exp=fffffffe", tx_word()); end
    endtask

    task automatic test_reset_mid_result();
        byte_q_t p;
        int t = 0;
        clear_obs();
        tx_mode = 2;
        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        while (!tx_valid_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        rst_ni = 1'b0;
        #1;
        checks++; if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_tx_valid got=%b exp=0", tx_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
        @(negedge clk);
        rst_ni = 1'b1;
        tx_mode = 0;
        repeat (10) @(negedge clk);
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL rst_mid_no_partial got=%0d exp=0", tx_q.size()); end
    endtask

    task automatic test_div();
        byte_q_t p;
        clear_obs();
`ifdef UART_ALU_DIV_EN
        p = '{8'h14, 8'h00, 8'h0C, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_tx(4);
        repeat (2) @(negedge clk);
        checks++; if (tx_word() !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_by_zero got=%08h exp=ffffffff", tx_word()); end
        clear_obs();
        p = '{8'h14, 8'h00, 8'h0C, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        wait_tx(4);
        repeat (2) @(negedge clk);
        checks++; if (tx_word() !== 32'h0000_0009) begin failures++; $display("FAIL div_64_7 got=%08h exp=00000009", tx_word()); end
        checks++; if (err_cnt != 0) begin failures++; $display("FAIL div_err got=%0d exp=0", err_cnt); end
`else
        p = '{8'h14, 8'h00, 8'h0C, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(p);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL div_off_drain busy got=%b exp=0", busy_o); end
        repeat (3) @(negedge clk);
        checks++; if (err_cnt != 1) begin failures++; $display("FAIL div_off_err got=%0d exp=1", err_cnt); end
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL div_off_no_tx got=%0d exp=0", tx_q.size()); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_single_and_xor();
        test_echo();
        test_malformed();
        test_backpressure();
        test_reset_mid_result();
        test_div();
        checks++;
        if (overlap_cnt != 0) begin
            failures++;
            $display("FAIL err_tx_overlap got=%0d exp=0", overlap_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
